// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - retirement trace record type and shared constants
package trace_pkg;

    localparam int          TRC_SEQ_W    = 16;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;
    localparam logic [4:0]  REG_X0       = 5'd0;

    typedef struct packed {
        logic [TRC_SEQ_W-1:0] seq;
        logic [31:0]          pc;
        logic [31:0]          instr;
        logic                 rd_we;
        logic [4:0]           rd;
        logic [31:0]          rd_data;
        logic                 mem_we;
        logic [31:0]          mem_addr;
        logic [31:0]          mem_data;
    } trace_rec_t;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - synchronous show-ahead FIFO of trace records
module trace_fifo
    import trace_pkg::*;
#(
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rstn_i,
    input  logic       clr,
    input  logic       push,
    input  trace_rec_t din,
    input  logic       pop,
    output trace_rec_t dout,
    output logic       full,
    output logic       empty,
    output logic [AW:0] count
);

    trace_rec_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rstn_i || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/retire_trace_collector.sv
// rtl/retire_trace_collector.sv - filters, tags and buffers WB retirement records
module retire_trace_collector
    import trace_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int SEQ_W  = 16,
    parameter int DROP_W = 16
) (
    input  logic                     clk,
    input  logic                     rstn_i,
    input  logic                     en_i,
    input  logic                     clr_i,
    input  logic [31:0]              pc_wb_i,
    input  logic [31:0]              instr_i,
    input  logic [4:0]               rd_addr_i,
    input  logic [31:0]              rd_data_i,
    input  logic                     regwrite_i,
    input  logic [31:0]              mem_addr_i,
    input  logic [31:0]              mem_data_i,
    input  logic                     mem_wrt_i,
    output logic                     trc_valid_o,
    input  logic                     trc_ready_i,
    output trace_rec_t               trc_o,
    output logic [$clog2(DEPTH):0]   fill_o,
    output logic                     overflow_o,
    output logic [DROP_W-1:0]        drop_cnt_o,
    output logic [31:0]              retire_cnt_o
);

    logic [SEQ_W-1:0] seq_q;
    logic             retire_evt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             push;
    logic             drop;
    logic             rd_we;
    trace_rec_t       rec;

    // A clear wins over a same-cycle retirement, so the event is masked by clr_i.
    assign retire_evt  = en_i && !clr_i && (instr_i != BUBBLE_INSTR);
    assign trc_valid_o = !fifo_empty;
    assign pop         = trc_valid_o && trc_ready_i;
    assign push        = retire_evt && (!fifo_full || pop);
    assign drop        = retire_evt && fifo_full && !pop;
    assign rd_we       = regwrite_i && (rd_addr_i != REG_X0);

    // Build the record, zeroing fields that carry no architectural effect.
    always_comb begin
        rec          = '0;
        rec.seq      = TRC_SEQ_W'(seq_q);
        rec.pc       = pc_wb_i;
        rec.instr    = instr_i;
        rec.rd_we    = rd_we;
        rec.rd       = rd_we ? rd_addr_i : REG_X0;
        rec.rd_data  = rd_we ? rd_data_i : 32'h0;
        rec.mem_we   = mem_wrt_i;
        rec.mem_addr = mem_wrt_i ? mem_addr_i : 32'h0;
        rec.mem_data = mem_wrt_i ? mem_data_i : 32'h0;
    end

    trace_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk    (clk),
        .rstn_i (rstn_i),
        .clr    (clr_i),
        .push   (push),
        .din    (rec),
        .pop    (pop),
        .dout   (trc_o),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fill_o)
    );

    // Sequence/retire counters advance on every event; drops are counted and flagged.
    always_ff @(posedge clk) begin
        if (!rstn_i || clr_i) begin
            seq_q        <= '0;
            retire_cnt_o <= '0;
            drop_cnt_o   <= '0;
            overflow_o   <= 1'b0;
        end else begin
            if (retire_evt) begin
                seq_q        <= seq_q + 1'b1;
                retire_cnt_o <= retire_cnt_o + 32'd1;
            end
            if (drop) begin
                overflow_o <= 1'b1;
                if (drop_cnt_o != '1) drop_cnt_o <= drop_cnt_o + 1'b1;
            end
        end
    end

endmodule
